// File: rtl/sad_trigger_qualifier_pkg.sv
// Shared types for the SAD trigger qualifier: FSM state encoding and default widths.
package sad_trigger_qualifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_PULSE   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DEF_COUNT_WIDTH   = 16;
  localparam int DEF_HOLDOFF_WIDTH = 20;
  localparam int DEF_PULSE_WIDTH   = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sad_trigger_qualifier_if.sv
// Control/status bundle between the SAD engines, register block and trigger qualifier.
// No valid/ready handshake: every signal is a level sampled on each clk_adc edge.
interface sad_trigger_qualifier_if #(
  parameter int pCOUNT_WIDTH   = 16,
  parameter int pHOLDOFF_WIDTH = 20,
  parameter int pPULSE_WIDTH   = 8
);
  import sad_trigger_qualifier_pkg::*;

  logic                      armed_and_ready;
  logic                      sad_trigger;
  logic [pPULSE_WIDTH-1:0]   cfg_pulse_width;
  logic [pHOLDOFF_WIDTH-1:0] cfg_holdoff;
  logic [pCOUNT_WIDTH-1:0]   cfg_max_triggers;
  logic                      trigger_out;
  logic                      busy;
  logic                      done;
  logic [pCOUNT_WIDTH-1:0]   trigger_count;
  logic [pCOUNT_WIDTH-1:0]   missed_count;
  state_t                    dbg_state;

  modport master (
    output armed_and_ready, sad_trigger, cfg_pulse_width, cfg_holdoff, cfg_max_triggers,
    input  trigger_out, busy, done, trigger_count, missed_count, dbg_state
  );

  modport slave (
    input  armed_and_ready, sad_trigger, cfg_pulse_width, cfg_holdoff, cfg_max_triggers,
    output trigger_out, busy, done, trigger_count, missed_count, dbg_state
  );

endinterface

// File: rtl/sad_trigger_qualifier.sv
// Edge-qualifies the raw SAD match, shapes it into a programmable-width pulse, applies
// holdoff and a per-arm trigger cap, and keeps saturating accepted/missed counters.
module sad_trigger_qualifier
  import sad_trigger_qualifier_pkg::*;
#(
  parameter int pCOUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int pHOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH,
  parameter int pPULSE_WIDTH   = DEF_PULSE_WIDTH
) (
  input  logic                     clk_adc,
  input  logic                     reset,
  sad_trigger_qualifier_if.slave   bus
);

  // One down-counter serves both the pulse and the holdoff phase.
  localparam int CNT_W = max_int(pPULSE_WIDTH, pHOLDOFF_WIDTH);

  state_t                    state, state_n;
  logic                      sad_trigger_r;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [pHOLDOFF_WIDTH-1:0] holdoff_lat, holdoff_n;
  logic [pCOUNT_WIDTH-1:0]   trigger_count, trig_cnt_n;
  logic [pCOUNT_WIDTH-1:0]   missed_count, miss_cnt_n;
  logic                      trig_edge;

  assign trig_edge = bus.sad_trigger & ~sad_trigger_r;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state         <= ST_IDLE;
      sad_trigger_r <= 1'b0;
      cnt           <= '0;
      holdoff_lat   <= '0;
      trigger_count <= '0;
      missed_count  <= '0;
    end else begin
      state         <= state_n;
      sad_trigger_r <= bus.sad_trigger;
      cnt           <= cnt_n;
      holdoff_lat   <= holdoff_n;
      trigger_count <= trig_cnt_n;
      missed_count  <= miss_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    holdoff_n  = holdoff_lat;
    trig_cnt_n = trigger_count;
    miss_cnt_n = missed_count;

    // Edges arriving while we cannot accept them are counted even as arm drops.
    if (trig_edge && (state == ST_PULSE || state == ST_HOLDOFF || state == ST_DONE) &&
        !(&missed_count))
      miss_cnt_n = missed_count + pCOUNT_WIDTH'(1);

    if (!bus.armed_and_ready) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n    = ST_WAIT;
          trig_cnt_n = '0;
          miss_cnt_n = '0;
        end
        ST_WAIT: begin
          if (trig_edge) begin
            state_n    = ST_PULSE;
            trig_cnt_n = (&trigger_count) ? trigger_count : trigger_count + pCOUNT_WIDTH'(1);
            cnt_n      = (bus.cfg_pulse_width == '0) ? '0
                                                     : CNT_W'(bus.cfg_pulse_width) - CNT_W'(1);
            holdoff_n  = bus.cfg_holdoff;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            if (bus.cfg_max_triggers != '0 && trigger_count == bus.cfg_max_triggers) begin
              state_n = ST_DONE;
            end else if (holdoff_lat != '0) begin
              state_n = ST_HOLDOFF;
              cnt_n   = CNT_W'(holdoff_lat) - CNT_W'(1);
            end else begin
              state_n = ST_WAIT;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) state_n = ST_WAIT;
          else           cnt_n   = cnt - CNT_W'(1);
        end
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.trigger_out   = (state == ST_PULSE);
  assign bus.busy          = (state == ST_PULSE) || (state == ST_HOLDOFF);
  assign bus.done          = (state == ST_DONE);
  assign bus.trigger_count = trigger_count;
  assign bus.missed_count  = missed_count;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_sad_trigger_qualifier.sv
// Bench for sad_trigger_qualifier: directed scenarios plus random traffic checked
// against a time-window reference model of the trigger qualification rules.
module tb_sad_trigger_qualifier;
  import sad_trigger_qualifier_pkg::*;

  localparam int CW   = 4;
  localparam int HW   = 20;
  localparam int PW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int OW   = 2 * CW + 3;

  localparam int P_IDLE = 0, P_WAIT = 1, P_PULSE = 2, P_HOLD = 3, P_DONE = 4;

  // ---------------- clock / reset ----------------
  logic clk_adc = 1'b0;
  logic reset;
  always #5 clk_adc = ~clk_adc;

  sad_trigger_qualifier_if #(.pCOUNT_WIDTH(CW), .pHOLDOFF_WIDTH(HW), .pPULSE_WIDTH(PW)) tq ();

  sad_trigger_qualifier #(.pCOUNT_WIDTH(CW), .pHOLDOFF_WIDTH(HW), .pPULSE_WIDTH(PW)) dut (
    .clk_adc (clk_adc),
    .reset   (reset),
    .bus     (tq.slave)
  );

  logic [OW-1:0] obs;
  assign obs = {tq.trigger_out, tq.busy, tq.done, tq.trigger_count, tq.missed_count};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // A session owns at most one "current" trigger: pulse [s, s+L), holdoff [s+L, s+L+H),
  // or done forever from s+L when it hit the cap.
  bit m_active, m_has, m_cap, m_prev;
  int m_s, m_L, m_H, m_tc, m_mc;

  function automatic int ph(input int t);
    if (!m_active) return P_IDLE;
    if (m_has) begin
      if (t < m_s + m_L) return P_PULSE;
      if (m_cap) return P_DONE;
      if (t < m_s + m_L + m_H) return P_HOLD;
    end
    return P_WAIT;
  endfunction

  function automatic logic [OW-1:0] model_exp();
    int p;
    p = ph(cyc);
    return {p == P_PULSE, (p == P_PULSE) || (p == P_HOLD), p == P_DONE, CW'(m_tc), CW'(m_mc)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_has = 0; m_cap = 0; m_prev = 0;
    m_s = 0; m_L = 0; m_H = 0; m_tc = 0; m_mc = 0;
  endtask

  task automatic model_step(input int t, input logic arm, input logic trig);
    int p, w, mx;
    bit rise;
    rise   = trig && !m_prev;
    m_prev = trig;
    p      = ph(t);
    w      = int'(tq.cfg_pulse_width);
    mx     = int'(tq.cfg_max_triggers);
    if (rise && (p == P_PULSE || p == P_HOLD || p == P_DONE))
      m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
    if (!arm) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1; m_tc = 0; m_mc = 0; m_has = 0; m_cap = 0;
    end else if (rise && p == P_WAIT) begin
      m_tc  = (m_tc < CMAX) ? m_tc + 1 : CMAX;
      m_has = 1;
      m_s   = t + 1;
      m_L   = (w == 0) ? 1 : w;
      m_H   = int'(tq.cfg_holdoff);
      m_cap = (mx != 0) && (m_tc == mx);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic arm, input logic trig);
    tq.armed_and_ready = arm;
    tq.sad_trigger     = trig;
    model_step(cyc, arm, trig);
    cyc++;
    @(negedge clk_adc);
  endtask

  task automatic set_cfg(input int w, input int h, input int mx);
    tq.cfg_pulse_width  = PW'(w);
    tq.cfg_holdoff      = HW'(h);
    tq.cfg_max_triggers = CW'(mx);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tq.armed_and_ready = 1'b0;
    tq.sad_trigger     = 1'b0;
    set_cfg(1, 0, 0);
    repeat (2) @(negedge clk_adc);
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    total++;
    if (tq.dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", tq.dbg_state, ST_IDLE);
    end
    reset = 1'b0;
    model_reset();
    cyc += 2;
    tick(1'b0, 1'b0);
    total++;
    if (obs !== model_exp()) begin
      bad++; $display("FAIL reset_idle got=%h exp=%h", obs, model_exp());
    end
  endtask

  task automatic test_single_pulse();
    int high_cnt = 0;
    set_cfg(4, 0, 0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, k == 10);
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL single_model k=%0d got=%h exp=%h", k + 1, obs, model_exp());
      end
      total++;
      if (tq.trigger_out !== ((k + 1 >= 11) && (k + 1 <= 14))) begin
        bad++; $display("FAIL single_window cyc=%0d got=%b", k + 1, tq.trigger_out);
      end
      if (tq.trigger_out === 1'b1) high_cnt++;
    end
    total++;
    if (tq.trigger_count !== CW'(1) || high_cnt != 4) begin
      bad++; $display("FAIL single_count got=%0d/%0d exp=1/4", tq.trigger_count, high_cnt);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_holdoff();
    logic prev_out = 1'b0;
    logic [31:0] want;
    set_cfg(2, 10, 0);
    tick(1'b1, 1'b0);
    exp_q = {32'd1, 32'd21};
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, (k == 0) || (k == 5) || (k == 20));
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL holdoff_model k=%0d got=%h exp=%h", k + 1, obs, model_exp());
      end
      if (tq.trigger_out === 1'b1 && prev_out === 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL holdoff_extra_pulse got=%0d exp=none", k + 1);
        end else begin
          want = exp_q.pop_front();
          if (want != 32'(k + 1)) begin
            bad++; $display("FAIL holdoff_pulse_start got=%0d exp=%0d", k + 1, want);
          end
        end
      end
      prev_out = tq.trigger_out;
    end
    total++;
    if (exp_q.size() != 0 || tq.missed_count !== CW'(1) || tq.trigger_count !== CW'(2)) begin
      bad++;
      $display("FAIL holdoff_counts got=tc%0d/mc%0d/left%0d exp=2/1/0",
               tq.trigger_count, tq.missed_count, exp_q.size());
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_cap();
    int pulses = 0;
    set_cfg(1, 0, 2);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, (k % 4) == 0);
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL cap_model k=%0d got=%h exp=%h", k + 1, obs, model_exp());
      end
      if (tq.trigger_out === 1'b1) pulses++;
    end
    total++;
    if (pulses != 2 || tq.done !== 1'b1 || tq.trigger_count !== CW'(2) ||
        tq.missed_count !== CW'(3)) begin
      bad++;
      $display("FAIL cap_result got=p%0d d%b tc%0d mc%0d exp=p2 d1 tc2 mc3",
               pulses, tq.done, tq.trigger_count, tq.missed_count);
    end
    tick(1'b0, 1'b0);
    total++;
    if (tq.dbg_state !== ST_IDLE || tq.done !== 1'b0 || tq.trigger_count !== CW'(2)) begin
      bad++; $display("FAIL cap_disarm_hold got=st%0d tc%0d exp=st0 tc2",
                      tq.dbg_state, tq.trigger_count);
    end
    tick(1'b1, 1'b0);
    total++;
    if (tq.trigger_count !== '0 || tq.missed_count !== '0 || tq.dbg_state !== ST_WAIT) begin
      bad++; $display("FAIL cap_rearm_clear got=tc%0d mc%0d st%0d exp=0/0/1",
                      tq.trigger_count, tq.missed_count, tq.dbg_state);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_level_hold();
    int rises = 0;
    logic prev_out = 1'b0;
    set_cfg(3, 2, 0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 56; k++) begin
      tick(1'b1, k < 50);
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL level_model k=%0d got=%h exp=%h", k + 1, obs, model_exp());
      end
      if (tq.trigger_out === 1'b1 && prev_out === 1'b0) rises++;
      prev_out = tq.trigger_out;
    end
    total++;
    if (rises != 1 || tq.trigger_count !== CW'(1) || tq.missed_count !== '0) begin
      bad++; $display("FAIL level_one_pulse got=r%0d tc%0d mc%0d exp=r1 tc1 mc0",
                      rises, tq.trigger_count, tq.missed_count);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_width_zero();
    int high_cnt = 0;
    set_cfg(0, 0, 0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, k == 1);
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL width0_model k=%0d got=%h exp=%h", k + 1, obs, model_exp());
      end
      if (tq.trigger_out === 1'b1) high_cnt++;
    end
    total++;
    if (high_cnt != 1) begin
      bad++; $display("FAIL width0_len got=%0d exp=1", high_cnt);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_arm_drop();
    set_cfg(8, 0, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    total++;
    if (tq.trigger_out !== 1'b1) begin
      bad++; $display("FAIL armdrop_third_cycle got=%b exp=1", tq.trigger_out);
    end
    tick(1'b0, 1'b0);
    total++;
    if (tq.trigger_out !== 1'b0 || tq.dbg_state !== ST_IDLE || tq.trigger_count !== CW'(1)) begin
      bad++; $display("FAIL armdrop_idle got=o%b st%0d tc%0d exp=o0 st0 tc1",
                      tq.trigger_out, tq.dbg_state, tq.trigger_count);
    end
    total++;
    if (obs !== model_exp()) begin
      bad++; $display("FAIL armdrop_model got=%h exp=%h", obs, model_exp());
    end
  endtask

  task automatic test_reset_holdoff();
    set_cfg(1, 20, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    total++;
    if (tq.dbg_state !== ST_HOLDOFF || tq.missed_count !== CW'(1) || obs !== model_exp()) begin
      bad++; $display("FAIL rsthold_pre got=st%0d %h exp=st3 %h",
                      tq.dbg_state, obs, model_exp());
    end
    reset = 1'b1;
    tq.sad_trigger = 1'b0;
    @(negedge clk_adc);
    total++;
    if (obs !== '0 || tq.dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL rsthold_clear got=%h st%0d exp=0 st0", obs, tq.dbg_state);
    end
    reset = 1'b0;
    model_reset();
    cyc++;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    set_cfg(1, 0, 0);
    tick(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
    end
    total++;
    if (tq.trigger_count !== CW'(CMAX) || obs !== model_exp()) begin
      bad++; $display("FAIL sat_trigger got=%0d exp=%0d", tq.trigger_count, CMAX);
    end
    set_cfg(1, 3, 0);
    for (int n = 0; n < 40; n++) begin
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
    end
    total++;
    if (tq.missed_count !== CW'(CMAX) || tq.trigger_count !== CW'(CMAX)) begin
      bad++; $display("FAIL sat_missed got=mc%0d tc%0d exp=%0d/%0d",
                      tq.missed_count, tq.trigger_count, CMAX, CMAX);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic arm = 1'b1;
    logic trig = 1'b0;
    int   off_left = 0;
    set_cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 4));
    for (int k = 0; k < 2500; k++) begin
      if (off_left > 0) begin
        off_left--;
        arm = (off_left == 0);
      end else if ($urandom_range(0, 49) == 0) begin
        arm = 1'b0;
        off_left = $urandom_range(1, 3);
        tq.cfg_max_triggers = CW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 11) == 0) begin
        tq.cfg_pulse_width = PW'($urandom_range(0, 5));
        tq.cfg_holdoff     = HW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 2) == 0) trig = ~trig;
      tick(arm, trig);
      total++;
      if (obs !== model_exp()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs, model_exp());
      end
    end
    tick(1'b0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    tq.armed_and_ready = 1'b0;
    tq.sad_trigger     = 1'b0;
    set_cfg(1, 0, 0);
    model_reset();
    test_reset();
    test_single_pulse();
    test_holdoff();
    test_cap();
    test_level_hold();
    test_width_zero();
    test_arm_drop();
    test_reset_holdoff();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
